// File: rtl/systolic_array.sv
// Weight-stationary M_SIZE x M_SIZE systolic GEMM array: weights shift down and stay resident,
// features flow down the columns, partial sums flow left-to-right and exit from the last column.
module systolic_array #(
  parameter int WIDTH  = 32,
  parameter int M_SIZE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_weight,
  input  logic [WIDTH*M_SIZE-1:0]   weight_in,
  input  logic [WIDTH*M_SIZE-1:0]   feature_in,
  output logic [WIDTH*M_SIZE-1:0]   result_out
);

  // Per-PE register outputs, exposed as wires so neighbours can read them.
  logic [WIDTH-1:0] w_w_q [M_SIZE][M_SIZE];
  logic [WIDTH-1:0] w_f_q [M_SIZE][M_SIZE];
  logic [WIDTH-1:0] w_p_q [M_SIZE][M_SIZE];

  genvar gi, gj;
  generate
    for (gi = 0; gi < M_SIZE; gi++) begin : g_row
      for (gj = 0; gj < M_SIZE; gj++) begin : g_col
        logic [WIDTH-1:0] r_w;
        logic [WIDTH-1:0] r_f;
        logic [WIDTH-1:0] r_p;
        logic [WIDTH-1:0] w_win;
        logic [WIDTH-1:0] w_fin;
        logic [WIDTH-1:0] w_pin;
        logic [WIDTH-1:0] w_prod;

        if (gi == 0) begin : g_top
          assign w_win = weight_in[gj*WIDTH +: WIDTH];
          assign w_fin = feature_in[gj*WIDTH +: WIDTH];
        end else begin : g_inner
          assign w_win = w_w_q[gi-1][gj];
          assign w_fin = w_f_q[gi-1][gj];
        end

        if (gj == 0) begin : g_left
          assign w_pin = '0;
        end else begin : g_chain
          assign w_pin = w_p_q[gi][gj-1];
        end

        // Product and sum both wrap modulo 2^WIDTH.
        assign w_prod = r_w * w_fin;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_w <= '0;
            r_f <= '0;
            r_p <= '0;
          end else begin
            r_f <= w_fin;
            r_p <= w_pin + w_prod;
            if (load_weight) begin
              r_w <= w_win;
            end
          end
        end

        assign w_w_q[gi][gj] = r_w;
        assign w_f_q[gi][gj] = r_f;
        assign w_p_q[gi][gj] = r_p;
      end

      assign result_out[gi*WIDTH +: WIDTH] = w_p_q[gi][M_SIZE-1];
    end
  endgenerate

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: reset, identity, table-driven single tiles,
// random back-to-back streaming against a closed-form GEMM model, and mid-stream reset.
module tb_systolic_array;
  localparam int WIDTH = 32;
  localparam int M     = 16;
  localparam int BW    = WIDTH * M;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_weight;
  logic [BW-1:0] weight_in;
  logic [BW-1:0] feature_in;
  logic [BW-1:0] result_out;

  systolic_array #(.WIDTH(WIDTH), .M_SIZE(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_weight(load_weight),
    .weight_in  (weight_in),
    .feature_in (feature_in),
    .result_out (result_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0]   m_w [M][M];
  logic [BW-1:0] hist [64];
  int            te_cnt;

  typedef struct {
    logic [31:0] w_scale;
    logic [31:0] w_off;
    logic [31:0] f_val;
    logic [31:0] e_scale;
    logic [31:0] e_off;
  } vec_t;

  vec_t tbl [5];

  task automatic check_vec(input string name, input int cyc, input logic [BW-1:0] act,
                           input logic [BW-1:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp_v);
  endtask

  // After edge te, lane r = sum_j W[r][j] * feature_in[j] as presented at edge te-(M-1-j)-r.
  function automatic logic [BW-1:0] model_out(input int te);
    logic [BW-1:0] v;
    logic [BW-1:0] h;
    logic [31:0]   acc;
    logic [31:0]   fv;
    int            d;
    v = '0;
    for (int r = 0; r < M; r++) begin
      acc = '0;
      for (int j = 0; j < M; j++) begin
        d = M - 1 - j + r;
        if (te >= d) begin
          h   = hist[(te - d) % 64];
          fv  = h[j*WIDTH +: WIDTH];
          acc = acc + m_w[r][j] * fv;
        end
      end
      v[r*WIDTH +: WIDTH] = acc;
    end
    return v;
  endfunction

  task automatic tick(input string name, input bit do_check);
    int te;
    te = te_cnt;
    hist[te % 64] = feature_in;
    @(posedge clk);
    #1;
    te_cnt++;
    if (do_check) check_vec(name, te, result_out, model_out(te));
  endtask

  task automatic clear_model();
    te_cnt = 0;
    for (int i = 0; i < 64; i++) hist[i] = '0;
    for (int r = 0; r < M; r++)
      for (int j = 0; j < M; j++) m_w[r][j] = '0;
  endtask

  task automatic drain();
    feature_in  = '0;
    load_weight = 1'b0;
    repeat (2*M) tick("drain", 1'b1);
  endtask

  task automatic load_weights();
    logic [BW-1:0] row;
    feature_in = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < M; j++) row[j*WIDTH +: WIDTH] = m_w[M-1-i][j];
      weight_in   = row;
      load_weight = 1'b1;
      tick("load", 1'b1);
    end
    load_weight = 1'b0;
    weight_in   = '0;
  endtask

  task automatic rand_inputs();
    for (int j = 0; j < M; j++) begin
      feature_in[j*WIDTH +: WIDTH] = $urandom();
      weight_in[j*WIDTH +: WIDTH]  = $urandom();
    end
    load_weight = 1'($urandom_range(0, 1));
  endtask

  // Entered 1ns after an edge; asserts reset between edges and checks the async clear.
  task automatic mid_reset();
    #1;
    rst = 1'b1;
    #1;
    check_vec("async_rst_immediate", te_cnt, result_out, '0);
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      @(posedge clk);
      #1;
      check_vec("rst_held", i, result_out, '0);
    end
    rst         = 1'b0;
    feature_in  = '0;
    weight_in   = '0;
    load_weight = 1'b0;
    clear_model();
  endtask

  task automatic stream(input string name, input int ntiles, input int abort_at);
    int s;
    for (int c = 0; c < ntiles*M + M - 1; c++) begin
      if (c == abort_at) begin
        mid_reset();
        return;
      end
      for (int j = 0; j < M; j++) begin
        s = c - j;
        feature_in[j*WIDTH +: WIDTH] = (s >= 0 && s < ntiles*M) ? $urandom_range(0, 1024) : 32'd0;
      end
      tick(name, 1'b1);
    end
    feature_in = '0;
    repeat (M) tick(name, 1'b1);
  endtask

  task automatic rand_weights();
    for (int r = 0; r < M; r++)
      for (int j = 0; j < M; j++) m_w[r][j] = $urandom();
  endtask

  initial begin
    logic [BW-1:0] exp_v;
    logic [31:0]   lane_v;
    int            k;

    tbl[0] = '{w_scale: 32'd1,          w_off: 32'd0,          f_val: 32'd1,          e_scale: 32'd16,         e_off: 32'd0};
    tbl[1] = '{w_scale: 32'd0,          w_off: 32'hFFFF_FFFF,  f_val: 32'hFFFF_FFFF,  e_scale: 32'd0,          e_off: 32'd16};
    tbl[2] = '{w_scale: 32'd0,          w_off: 32'd3,          f_val: 32'd5,          e_scale: 32'd0,          e_off: 32'd240};
    tbl[3] = '{w_scale: 32'h0100_0000,  w_off: 32'd0,          f_val: 32'd1,          e_scale: 32'h1000_0000,  e_off: 32'd0};
    tbl[4] = '{w_scale: 32'd2,          w_off: 32'd1,          f_val: 32'd7,          e_scale: 32'd224,        e_off: 32'd112};

    rst         = 1'b0;
    load_weight = 1'b0;
    weight_in   = '0;
    feature_in  = '0;
    clear_model();

    // Reset with inputs toggling, then release with zero features.
    #2;
    rst = 1'b1;
    #1;
    check_vec("reset_initial", 0, result_out, '0);
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      @(posedge clk);
      #1;
      check_vec("reset_hold", i, result_out, '0);
    end
    rst         = 1'b0;
    feature_in  = '0;
    weight_in   = '0;
    load_weight = 1'b0;
    clear_model();
    for (int i = 0; i < 8; i++) begin
      tick("post_reset", 1'b0);
      check_vec("post_reset", i, result_out, '0);
    end
    $display("scenario reset: %0d/%0d so far", n_pass, n_checks);

    // Identity weights: whole output vector equals the input vector M edges earlier.
    drain();
    for (int r = 0; r < M; r++)
      for (int j = 0; j < M; j++) m_w[r][j] = (r == j) ? 32'd1 : 32'd0;
    load_weights();
    for (int i = 0; i < 200; i++) begin
      for (int j = 0; j < M; j++) feature_in[j*WIDTH +: WIDTH] = $urandom();
      tick("identity", 1'b0);
      check_vec("identity", i, result_out, hist[(te_cnt - M) % 64]);
    end
    $display("scenario identity: %0d/%0d so far", n_pass, n_checks);

    // Single-tile table vectors with hand-computed results.
    for (int v = 0; v < 5; v++) begin
      drain();
      for (int r = 0; r < M; r++)
        for (int j = 0; j < M; j++) m_w[r][j] = tbl[v].w_scale * (r + 1) + tbl[v].w_off;
      load_weights();
      for (int c = 0; c < 3*M; c++) begin
        for (int j = 0; j < M; j++)
          feature_in[j*WIDTH +: WIDTH] = (c - j >= 0 && c - j < M) ? tbl[v].f_val : 32'd0;
        tick("tile", 1'b0);
        exp_v = '0;
        for (int r = 0; r < M; r++) begin
          k = c - (M - 1) - r;
          lane_v = tbl[v].e_scale * (r + 1) + tbl[v].e_off;
          if (k >= 0 && k < M) exp_v[r*WIDTH +: WIDTH] = lane_v;
        end
        check_vec($sformatf("tile_vec%0d", v), c, result_out, exp_v);
      end
      $display("table vector %0d: %0d/%0d so far", v, n_pass, n_checks);
    end

    // Random weights, 1024 back-to-back random tiles.
    drain();
    rand_weights();
    load_weights();
    stream("stream", 1024, -1);
    $display("scenario stream: %0d/%0d so far", n_pass, n_checks);

    // Reset in the middle of a stream, then reload and restream.
    drain();
    rand_weights();
    load_weights();
    stream("stream_pre_rst", 64, 300);
    drain();
    rand_weights();
    load_weights();
    stream("stream_post_rst", 256, -1);
    $display("scenario mid-stream reset: %0d/%0d so far", n_pass, n_checks);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
